// File: rtl/multicycle_ripple_adder_if.sv
// Handshake bundle for the multi-cycle adder. Upstream hands over operands with
// in_valid/in_ready, and the result comes back with out_valid/out_ready.
interface multicycle_ripple_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );
endinterface

// File: rtl/multicycle_ripple_adder.sv
// Add/subtract unit that processes CHUNK bits per clock. A registered carry links
// one chunk to the next, so the combinational ripple path is only CHUNK bits long.
module multicycle_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_ripple_adder_if.slave   bus
);
    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = WIDTH / SAFE_CHUNK;
    localparam int KW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int NSLOT      = 1 << KW;

    generate
        if (CHUNK < 1 || (WIDTH % SAFE_CHUNK) != 0) begin : g_param_check
            $error("multicycle_ripple_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] beff_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] sum_q;
    logic             co_q;
    logic             ovf_q;

    // The slice tables are padded to a power of two so k_q indexes them at full width.
    // The padding slots are never selected.
    logic [SAFE_CHUNK-1:0] a_sl [NSLOT];
    logic [SAFE_CHUNK-1:0] b_sl [NSLOT];

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slice
            if (gi < NCHUNK) begin : g_real
                assign a_sl[gi] = a_q[gi*SAFE_CHUNK +: SAFE_CHUNK];
                assign b_sl[gi] = beff_q[gi*SAFE_CHUNK +: SAFE_CHUNK];
            end else begin : g_pad
                assign a_sl[gi] = '0;
                assign b_sl[gi] = '0;
            end
        end
    endgenerate

    logic [SAFE_CHUNK:0] chunk_sum;
    logic                last_chunk;

    assign chunk_sum  = {1'b0, a_sl[k_q]} + {1'b0, b_sl[k_q]} + (SAFE_CHUNK+1)'(carry_q);
    assign last_chunk = (k_q == KW'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            beff_q  <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is computed as A + ~B + ~borrow_in.
                        a_q     <= bus.a;
                        beff_q  <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ? ~bus.ci : bus.ci;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (k_q == KW'(i)) begin
                            sum_q[i*SAFE_CHUNK +: SAFE_CHUNK] <= chunk_sum[SAFE_CHUNK-1:0];
                        end
                    end
                    carry_q <= chunk_sum[SAFE_CHUNK];
                    if (last_chunk) begin
                        co_q    <= chunk_sum[SAFE_CHUNK];
                        ovf_q   <= (a_q[WIDTH-1] == beff_q[WIDTH-1]) &&
                                   (chunk_sum[SAFE_CHUNK-1] != a_q[WIDTH-1]);
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_multicycle_ripple_adder.sv
// Bench for multicycle_ripple_adder: 16/4, 8/8 and 8/1 builds, directed vectors,
// backpressure and reset corner cases, then random operations against an arithmetic model.
module tb_multicycle_ripple_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a_drv = '0;
    logic [15:0] b_drv = '0;
    logic        ci_drv = 1'b0;
    logic        sub_drv = 1'b0;
    logic        out_ready_drv = 1'b1;
    logic [2:0]  in_valid_drv = '0;

    multicycle_ripple_adder_if #(.WIDTH(16)) if16 ();
    multicycle_ripple_adder_if #(.WIDTH(8))  if8a ();
    multicycle_ripple_adder_if #(.WIDTH(8))  if8b ();

    assign if16.in_valid = in_valid_drv[0];
    assign if16.a = a_drv;
    assign if16.b = b_drv;
    assign if16.ci = ci_drv;
    assign if16.sub = sub_drv;
    assign if16.out_ready = out_ready_drv;
    assign if8a.in_valid = in_valid_drv[1];
    assign if8a.a = a_drv[7:0];
    assign if8a.b = b_drv[7:0];
    assign if8a.ci = ci_drv;
    assign if8a.sub = sub_drv;
    assign if8a.out_ready = out_ready_drv;
    assign if8b.in_valid = in_valid_drv[2];
    assign if8b.a = a_drv[7:0];
    assign if8b.b = b_drv[7:0];
    assign if8b.ci = ci_drv;
    assign if8b.sub = sub_drv;
    assign if8b.out_ready = out_ready_drv;

    multicycle_ripple_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    multicycle_ripple_adder #(.WIDTH(8),  .CHUNK(8)) dut8a (.clk(clk), .rst(rst), .bus(if8a.slave));
    multicycle_ripple_adder #(.WIDTH(8),  .CHUNK(1)) dut8b (.clk(clk), .rst(rst), .bus(if8b.slave));

    typedef struct packed {
        logic        in_ready;
        logic        out_valid;
        logic [15:0] sum;
        logic        co;
        logic        ovf;
    } st_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] sum;
        logic        co;
        logic        ovf;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int nch [3] = '{4, 1, 8};
    int wid [3] = '{16, 8, 8};

    function automatic st_t rd(input int w);
        st_t r;
        case (w)
            0:       r = '{if16.in_ready, if16.out_valid, if16.sum, if16.co, if16.ovf};
            1:       r = '{if8a.in_ready, if8a.out_valid, {8'h00, if8a.sum}, if8a.co, if8a.ovf};
            default: r = '{if8b.in_ready, if8b.out_valid, {8'h00, if8b.sum}, if8b.co, if8b.ovf};
        endcase
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Signed and unsigned results computed as plain integers; carry/borrow and
    // overflow come from range tests on those integers.
    task automatic model(input int w, input longint a, input longint b, input bit ci, input bit sub,
                         output longint s, output bit co, output bit ovf);
        longint m, sa, sb, r, sr;
        m  = longint'(1) << w;
        sa = (a >= m/2) ? a - m : a;
        sb = (b >= m/2) ? b - m : b;
        if (!sub) begin
            r  = a + b + longint'(ci);
            sr = sa + sb + longint'(ci);
            co = (r >= m);
        end else begin
            r  = a - b - longint'(ci);
            sr = sa - sb - longint'(ci);
            co = (r >= 0);
        end
        s   = ((r % m) + m) % m;
        ovf = (sr >= m/2) || (sr < -(m/2));
    endtask

    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sub, input int stall,
                          output st_t res, output int lat);
        int guard;
        guard = 0;
        while (!rd(w).in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!rd(w).in_ready) check("in_ready_timeout", 0, 1);
        a_drv = a;
        b_drv = b;
        ci_drv = ci;
        sub_drv = sub;
        out_ready_drv = (stall == 0);
        in_valid_drv[w] = 1'b1;
        step();
        in_valid_drv[w] = 1'b0;
        lat = 0;
        while (!rd(w).out_valid && lat < 64) begin
            step();
            lat++;
        end
        for (int i = 0; i < stall; i++) step();
        res = rd(w);
        out_ready_drv = 1'b1;
        step();
    endtask

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 expected=0");
        $fatal(1, "timeout");
    end

    initial begin
        st_t r;
        int lat;
        bit bad;
        longint es;
        bit eco, eovf;

        vecs[0] = '{16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFE, 1'b1, 1'b1};
        vecs[5] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};

        // Reset state
        step();
        step();
        r = rd(0);
        check("rst_out_valid", r.out_valid, 0);
        check("rst_sum", r.sum, 0);
        check("rst_co", r.co, 0);
        check("rst_ovf", r.ovf, 0);
        check("rst_in_ready", r.in_ready, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", rd(0).in_ready, 1);
        step();

        for (int i = 0; i < 6; i++) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, i % 2, r, lat);
            $display("vec %0d: a=%h b=%h ci=%0d sub=%0d -> sum=%h co=%0d ovf=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, r.sum, r.co, r.ovf, lat);
            check($sformatf("vec%0d_sum", i), r.sum, vecs[i].sum);
            check($sformatf("vec%0d_co", i), r.co, vecs[i].co);
            check($sformatf("vec%0d_ovf", i), r.ovf, vecs[i].ovf);
            check($sformatf("vec%0d_lat", i), lat, 4);
        end

        // Backpressure: held result, new operands offered but not taken
        a_drv = 16'h1234; b_drv = 16'h0FED; ci_drv = 1'b0; sub_drv = 1'b0;
        out_ready_drv = 1'b0;
        in_valid_drv[0] = 1'b1;
        step();
        in_valid_drv[0] = 1'b0;
        lat = 0;
        while (!rd(0).out_valid && lat < 64) begin step(); lat++; end
        check("bp_lat", lat, 4);
        a_drv = 16'hFFFF; b_drv = 16'hFFFF;
        in_valid_drv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            r = rd(0);
            $display("bp cycle %0d: out_valid=%0d in_ready=%0d sum=%h", i, r.out_valid, r.in_ready, r.sum);
            check("bp_out_valid", r.out_valid, 1);
            check("bp_in_ready", r.in_ready, 0);
            check("bp_sum", r.sum, 16'h2221);
            check("bp_co", r.co, 0);
            check("bp_ovf", r.ovf, 0);
        end
        out_ready_drv = 1'b1;
        step();
        check("bp_release_in_ready", rd(0).in_ready, 1);
        check("bp_release_out_valid", rd(0).out_valid, 0);
        step();
        in_valid_drv[0] = 1'b0;
        lat = 0;
        while (!rd(0).out_valid && lat < 64) begin step(); lat++; end
        r = rd(0);
        $display("bp next op: sum=%h co=%0d ovf=%0d lat=%0d", r.sum, r.co, r.ovf, lat);
        check("bp_next_lat", lat, 4);
        check("bp_next_sum", r.sum, 16'hFFFE);
        check("bp_next_co", r.co, 1);
        check("bp_next_ovf", r.ovf, 0);
        step();

        // Reset while k==2
        a_drv = 16'h1111; b_drv = 16'h2222; ci_drv = 1'b0; sub_drv = 1'b0;
        in_valid_drv[0] = 1'b1;
        step();
        in_valid_drv[0] = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("midrst_in_ready_comb", rd(0).in_ready, 0);
        step();
        r = rd(0);
        $display("mid-op reset: out_valid=%0d sum=%h co=%0d ovf=%0d in_ready=%0d",
                 r.out_valid, r.sum, r.co, r.ovf, r.in_ready);
        check("midrst_out_valid", r.out_valid, 0);
        check("midrst_sum", r.sum, 0);
        check("midrst_co", r.co, 0);
        check("midrst_ovf", r.ovf, 0);
        check("midrst_in_ready", r.in_ready, 0);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rd(0).out_valid) bad = 1'b1;
        end
        check("midrst_no_partial", bad, 0);
        run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, r, lat);
        $display("post-reset op: sum=%h lat=%0d", r.sum, lat);
        check("postrst_sum", r.sum, 16'h0100);
        check("postrst_lat", lat, 4);

        // Narrow builds: single-chunk and one-bit-per-cycle
        for (int w = 1; w < 3; w++) begin
            run_op(w, 16'h00FF, 16'h0001, 1'b1, 1'b0, 0, r, lat);
            $display("w8 dut%0d: sum=%h co=%0d ovf=%0d lat=%0d", w, r.sum, r.co, r.ovf, lat);
            check($sformatf("w8_%0d_sum", w), r.sum, 16'h0001);
            check($sformatf("w8_%0d_co", w), r.co, 1);
            check($sformatf("w8_%0d_ovf", w), r.ovf, 0);
            check($sformatf("w8_%0d_lat", w), lat, nch[w]);
        end

        // Random operations against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            int w;
            logic [15:0] ra, rb;
            logic rci, rsub;
            w = int'($urandom_range(0, 2));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (wid[w] == 8) begin
                ra[15:8] = 8'h00;
                rb[15:8] = 8'h00;
            end
            rci = 1'($urandom);
            rsub = 1'($urandom);
            model(wid[w], longint'(ra), longint'(rb), rci, rsub, es, eco, eovf);
            run_op(w, ra, rb, rci, rsub, int'($urandom_range(0, 2)), r, lat);
            $display("rand %0d dut%0d: a=%h b=%h ci=%0d sub=%0d -> sum=%h co=%0d ovf=%0d lat=%0d",
                     n, w, ra, rb, rci, rsub, r.sum, r.co, r.ovf, lat);
            check("rand_sum", r.sum, es);
            check("rand_co", r.co, eco);
            check("rand_ovf", r.ovf, eovf);
            check("rand_lat", lat, nch[w]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
